axi_wr_slave_mem: RTL

Memory-backed AXI3 write-channel responder: the slave end of the AW/W/B channels that the bench's master driver and the `drv_cb` clocking block drive. It accepts one write burst at a time, stores beats into an internal byte-strobed memory, and returns a B response with the matching ID. It serves as the RTL DUT-side target for write traffic and for checking write-response protocol.

---
 rtl/axi_pkg.sv | 36 +++
 rtl/axi_burst_addr_gen.sv | 52 +++++
 rtl/axi_wr_slave_mem.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI3 types for the memory-backed write slave and its address
// generator: burst and response encodings, the write-slave FSM state type,
// the ID width, and a helper that tells whether a WRAP length is legal.
// -----------------------------------------------------------------------------
package axi_pkg;

   localparam int AXI_ID_W = 4;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } axi_burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [1:0] {
      WR_IDLE = 2'b00,
      WR_DATA = 2'b01,
      WR_RESP = 2'b10
   } wr_state_e;

   // A WRAP burst must carry 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [3:0] len);
      return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_burst_addr_gen
// Combinational AXI next-beat address: FIXED holds, INCR steps by 1<<size,
// WRAP steps by 1<<size inside the aligned (len+1)<<size byte window.
// Optional feature macro: AXI_WR_WRAP_BURST_EN (without it WRAP holds the
// address, since WRAP bursts are then never written).
// Ports:
//   addr_i      current beat byte address
//   size_i      log2 bytes per beat
//   len_i       beats minus 1
//   burst_i     burst type
//   next_addr_o byte address of the following beat
// -----------------------------------------------------------------------------
module axi_burst_addr_gen
   import axi_pkg::*;
(
   input  logic [31:0] addr_i,
   input  logic [2:0]  size_i,
   input  logic [3:0]  len_i,
   input  axi_burst_e  burst_i,
   output logic [31:0] next_addr_o
);

   logic [31:0] incr_addr;

   assign incr_addr = addr_i + (32'd1 << size_i);

`ifdef AXI_WR_WRAP_BURST_EN
   logic [31:0] wrap_mask;

   // Window size is a power of two for legal WRAP bursts, so a mask selects
   // the offset bits that move while the window base stays fixed.
   assign wrap_mask = (({28'd0, len_i} + 32'd1) << size_i) - 32'd1;
`else
   logic unused_len;

   assign unused_len = ^len_i;
`endif

   always_comb begin
      next_addr_o = addr_i;
      case (burst_i)
         BURST_FIXED: next_addr_o = addr_i;
         BURST_INCR:  next_addr_o = incr_addr;
`ifdef AXI_WR_WRAP_BURST_EN
         BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
         default:     next_addr_o = addr_i;
      endcase
   end

endmodule

// File: rtl/axi_wr_slave_mem.sv
// -----------------------------------------------------------------------------
// axi_wr_slave_mem
// Memory-backed AXI3 write responder: accepts one AW/W burst at a time,
// writes strobed bytes into an internal memory and returns a B response
// carrying the accepted ID.
// Optional feature macro: AXI_WR_WRAP_BURST_EN (WRAP bursts supported; when
// undefined, WRAP is treated like the reserved burst type).
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   awid/awaddr/awlen/awsize/awburst/awvalid, awready   write address channel
//   wid/wdata/wstrb/wlast/wvalid, wready                write data channel
//   bid/bresp/bvalid, bready                            write response channel
//   dbg_state_o                   current FSM state (observation only)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready/valid outputs here are registered and only change on
// clock edges, and B outputs hold stable while bvalid is high and bready low.
// -----------------------------------------------------------------------------
module axi_wr_slave_mem
   import axi_pkg::*;
#(
   parameter int DATA_BUSWIDTH = 32,
   parameter int MEM_DEPTH     = 1024
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [AXI_ID_W-1:0]        awid,
   input  logic [31:0]                awaddr,
   input  logic [3:0]                 awlen,
   input  logic [2:0]                 awsize,
   input  logic [1:0]                 awburst,
   input  logic                       awvalid,
   output logic                       awready,
   input  logic [AXI_ID_W-1:0]        wid,
   input  logic [DATA_BUSWIDTH-1:0]   wdata,
   input  logic [DATA_BUSWIDTH/8-1:0] wstrb,
   input  logic                       wlast,
   input  logic                       wvalid,
   output logic                       wready,
   output logic [AXI_ID_W-1:0]        bid,
   output logic [1:0]                 bresp,
   output logic                       bvalid,
   input  logic                       bready,
   output wr_state_e                  dbg_state_o
);

   localparam int          STRB_W    = DATA_BUSWIDTH / 8;
   localparam int          LANE_BITS = $clog2(STRB_W);
   localparam int          IDX_W     = $clog2(MEM_DEPTH);
   localparam logic [2:0]  MAX_SIZE  = 3'(LANE_BITS);
   localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH * STRB_W);

   wr_state_e             state_q, state_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic [AXI_ID_W-1:0]   bid_q, bid_d;
   axi_resp_e             bresp_q, bresp_d;

   logic [AXI_ID_W-1:0]   id_q, id_d;
   logic [31:0]           addr_q, addr_d;
   logic [3:0]            len_q, len_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [2:0]            size_q, size_d;
   axi_burst_e            burst_q, burst_d;
   axi_resp_e             resp_q, resp_d;
   logic                  supp_q, supp_d;

   logic [DATA_BUSWIDTH-1:0] mem_q [MEM_DEPTH];

   axi_burst_e  aw_burst;
   logic [32:0] beat_bytes, total_bytes, end_byte;
   logic        aw_decerr, aw_slverr;
   logic        aw_fire, w_fire, b_fire, last_beat, w_done, beat_err;
   logic [31:0] next_addr;
   logic [IDX_W-1:0] word_idx;

   assign aw_burst  = axi_burst_e'(awburst);
   assign aw_fire   = awvalid && awready_q;
   assign w_fire    = wvalid && wready_q;
   assign b_fire    = bvalid_q && bready;
   assign last_beat = (cnt_q == len_q);
   // Either the counted last beat or an early wlast closes the burst.
   assign w_done    = w_fire && (last_beat || wlast);
   assign beat_err  = (wid != id_q) || (last_beat != wlast);
   assign word_idx  = addr_q[LANE_BITS +: IDX_W];

   axi_burst_addr_gen u_addr_gen (
      .addr_i      (addr_q),
      .size_i      (size_q),
      .len_i       (len_q),
      .burst_i     (burst_q),
      .next_addr_o (next_addr)
   );

   // Burst legality and range, judged once when the address is accepted.
   always_comb begin
      beat_bytes  = 33'd1 << awsize;
      total_bytes = ({29'd0, awlen} + 33'd1) << awsize;
      case (aw_burst)
         BURST_FIXED: end_byte = {1'b0, awaddr} + beat_bytes - 33'd1;
`ifdef AXI_WR_WRAP_BURST_EN
         BURST_WRAP:  end_byte = {1'b0, awaddr} | (total_bytes - 33'd1);
`endif
         default:     end_byte = {1'b0, awaddr} + total_bytes - 33'd1;
      endcase
      aw_decerr = (end_byte >= MEM_BYTES);
      aw_slverr = (aw_burst == BURST_RSVD) || (awsize > MAX_SIZE);
`ifdef AXI_WR_WRAP_BURST_EN
      if ((aw_burst == BURST_WRAP) &&
          (!wrap_len_ok(awlen) || ((({1'b0, awaddr}) & (beat_bytes - 33'd1)) != 33'd0)))
         aw_slverr = 1'b1;
`else
      if (aw_burst == BURST_WRAP)
         aw_slverr = 1'b1;
`endif
   end

   // Burst context: latched on AW, advanced per accepted W beat.
   always_comb begin
      id_d    = id_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      size_d  = size_q;
      burst_d = burst_q;
      resp_d  = resp_q;
      supp_d  = supp_q;
      if (aw_fire) begin
         id_d    = awid;
         addr_d  = awaddr;
         len_d   = awlen;
         size_d  = awsize;
         burst_d = aw_burst;
         cnt_d   = '0;
         supp_d  = aw_decerr || aw_slverr;
         if (aw_decerr)      resp_d = RESP_DECERR;
         else if (aw_slverr) resp_d = RESP_SLVERR;
         else                resp_d = RESP_OKAY;
      end else if (w_fire) begin
         addr_d = next_addr;
         cnt_d  = cnt_q + 4'd1;
         // DECERR outranks anything a beat can report.
         if (beat_err && (resp_q != RESP_DECERR))
            resp_d = RESP_SLVERR;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         WR_IDLE: if (aw_fire) state_d = WR_DATA;
         WR_DATA: if (w_done)  state_d = WR_RESP;
         WR_RESP: if (b_fire)  state_d = WR_IDLE;
         default:              state_d = WR_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they land in flops.
   always_comb begin
      awready_d = 1'b0;
      wready_d  = 1'b0;
      bvalid_d  = 1'b0;
      bid_d     = '0;
      bresp_d   = RESP_OKAY;
      case (state_d)
         WR_IDLE: awready_d = 1'b1;
         WR_DATA: wready_d  = 1'b1;
         WR_RESP: begin
            bvalid_d = 1'b1;
            bid_d    = id_d;
            bresp_d  = resp_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= WR_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= RESP_OKAY;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         size_q    <= '0;
         burst_q   <= BURST_FIXED;
         resp_q    <= RESP_OKAY;
         supp_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         resp_q    <= resp_d;
         supp_q    <= supp_d;
      end
   end

   // Storage has no reset; contents survive an abandoned burst.
   always_ff @(posedge aclk) begin
      if (w_fire && !supp_q) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) mem_q[word_idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   assign awready     = awready_q;
   assign wready      = wready_q;
   assign bvalid      = bvalid_q;
   assign bid         = bid_q;
   assign bresp       = bresp_q;
   assign dbg_state_o = state_q;

endmodule
